// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared types and helpers for the reset release sequencer
package rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_REL      = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_GAP      = 3'd3,
        ST_READY    = 3'd4
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Lowest set bit of vec at or above start; bit 3 of the result flags "none".
    function automatic logic [3:0] next_set_bit(input logic [7:0] vec, input logic [3:0] start);
        logic [3:0] r;
        r = 4'b1000;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i] && (i >= int'(start))) begin
                r = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rst_seq_tmr.sv
// rtl/rst_seq_tmr.sv - loadable saturating up-counter with clear, enable and terminal compare
module rst_seq_tmr #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic [W-1:0] term_val_i,
    output logic [W-1:0] cnt_o,
    output logic         term_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign term_o = (cnt_q == term_val_i);

endmodule

// File: rtl/rst_seq_ctrl.sv
// rtl/rst_seq_ctrl.sv - per-domain reset release sequencer with software reset
// RST_SEQ_WDOG_EN enables the ack timeout watchdog (TIMEOUT_ERR / ERR_DOM).
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOM     = 4,
    parameter int HOLD_CYC    = 8,
    parameter int GAP_CYC     = 4,
    parameter int ACK_TIMEOUT = 64,
    localparam int IW         = (NUM_DOM > 1) ? clog2(NUM_DOM) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_DOM-1:0] dom_ack_i,
    input  logic               sw_rst_req_i,
    input  logic [NUM_DOM-1:0] sw_rst_mask_i,
    output logic [NUM_DOM-1:0] dom_rst_n_o,
    output logic               busy_o,
    output logic               all_ready_o,
    output logic               timeout_err_o,
    output logic [IW-1:0]      err_dom_o
);

    localparam int TMAX0 = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int TMAX  = (TMAX0 > ACK_TIMEOUT) ? TMAX0 : ACK_TIMEOUT;
    localparam int TW    = (clog2(TMAX + 1) > 0) ? clog2(TMAX + 1) : 1;

    state_e             state_q, state_d;
    logic [NUM_DOM-1:0] tgt_q, tgt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [NUM_DOM-1:0] dom_rst_n_q, dom_rst_n_d;
    logic               busy_q;
    logic               all_ready_q;

    logic               tmr_clr;
    logic               tmr_en;
    logic [TW-1:0]      tmr_term_val;
    logic [TW-1:0]      tmr_cnt;
    logic               tmr_term;

    logic [7:0]         tgt_ext;
    logic [3:0]         first_set;
    logic [3:0]         after_idx;

    always_comb begin
        tgt_ext                = '0;
        tgt_ext[NUM_DOM-1:0]   = tgt_q;
    end

    assign first_set = next_set_bit(tgt_ext, 4'd0);
    assign after_idx = next_set_bit(tgt_ext, 4'(idx_q) + 4'd1);

`ifdef RST_SEQ_WDOG_EN
    logic               timeout_err_q, timeout_err_d;
    logic [IW-1:0]      err_dom_q, err_dom_d;
`endif

    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        idx_d        = idx_q;
        dom_rst_n_d  = dom_rst_n_q;
        tmr_clr      = 1'b0;
        tmr_en       = 1'b0;
        tmr_term_val = '0;
`ifdef RST_SEQ_WDOG_EN
        timeout_err_d = timeout_err_q;
        err_dom_d     = err_dom_q;
`endif
        case (state_q)
            ST_HOLD: begin
                dom_rst_n_d  = dom_rst_n_q & ~tgt_q;
                tmr_term_val = TW'(HOLD_CYC - 1);
                if (tmr_term) begin
                    state_d = ST_REL;
                    idx_d   = IW'(first_set[2:0]);
                    tmr_clr = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_REL: begin
                dom_rst_n_d[idx_q] = 1'b1;
                tmr_clr            = 1'b1;
                state_d            = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (dom_ack_i[idx_q]) begin
                    state_d = ST_GAP;
                    tmr_clr = 1'b1;
                end else begin
`ifdef RST_SEQ_WDOG_EN
                    // The released domain stays out of reset; a timeout only flags it.
                    tmr_term_val = TW'(ACK_TIMEOUT - 1);
                    if (tmr_term) begin
                        timeout_err_d = 1'b1;
                        err_dom_d     = idx_q;
                        state_d       = ST_GAP;
                        tmr_clr       = 1'b1;
                    end else begin
                        tmr_en = 1'b1;
                    end
`endif
                end
            end
            ST_GAP: begin
                tmr_term_val = TW'(GAP_CYC);
                if (tmr_term) begin
                    tmr_clr = 1'b1;
                    if (after_idx[3]) begin
                        state_d = ST_READY;
                    end else begin
                        state_d = ST_REL;
                        idx_d   = IW'(after_idx[2:0]);
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_READY: begin
                if (sw_rst_req_i && (sw_rst_mask_i != '0)) begin
                    tgt_d       = sw_rst_mask_i;
                    dom_rst_n_d = dom_rst_n_q & ~sw_rst_mask_i;
                    state_d     = ST_HOLD;
                    tmr_clr     = 1'b1;
                end
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_HOLD;
            tgt_q       <= '1;
            idx_q       <= '0;
            dom_rst_n_q <= '0;
            busy_q      <= 1'b1;
            all_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            idx_q       <= idx_d;
            dom_rst_n_q <= dom_rst_n_d;
            busy_q      <= (state_d != ST_READY);
            all_ready_q <= (state_d == ST_READY) && (&dom_ack_i);
        end
    end

`ifdef RST_SEQ_WDOG_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timeout_err_q <= 1'b0;
            err_dom_q     <= '0;
        end else begin
            timeout_err_q <= timeout_err_d;
            err_dom_q     <= err_dom_d;
        end
    end

    assign timeout_err_o = timeout_err_q;
    assign err_dom_o     = err_dom_q;
`else
    assign timeout_err_o = 1'b0;
    assign err_dom_o     = '0;
`endif

    rst_seq_tmr #(
        .W (TW)
    ) u_tmr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (tmr_clr),
        .en_i       (tmr_en),
        .load_i     (1'b0),
        .load_val_i ({TW{1'b0}}),
        .term_val_i (tmr_term_val),
        .cnt_o      (tmr_cnt),
        .term_o     (tmr_term)
    );

    assign dom_rst_n_o = dom_rst_n_q;
    assign busy_o      = busy_q;
    assign all_ready_o = all_ready_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb/tb_rst_seq_ctrl.sv - directed self-checking bench for rst_seq_ctrl
module tb_rst_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic [3:0] mask = 4'h0;
    logic [3:0] ack = 4'h0;
    logic [3:0] d1 = 4'h0;
    logic [3:0] d2 = 4'h0;
    logic [3:0] dead = 4'h0;
    logic [3:0] dom;
    logic       busy;
    logic       all_ready;
    logic       terr;
    logic [1:0] err_dom;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    rst_seq_ctrl #(
        .NUM_DOM     (4),
        .HOLD_CYC    (4),
        .GAP_CYC     (2),
        .ACK_TIMEOUT (16)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .dom_ack_i     (ack),
        .sw_rst_req_i  (req),
        .sw_rst_mask_i (mask),
        .dom_rst_n_o   (dom),
        .busy_o        (busy),
        .all_ready_o   (all_ready),
        .timeout_err_o (terr),
        .err_dom_o     (err_dom)
    );

    always #5 clk = ~clk;

    // Domain model: ack follows the domain reset 3 cycles later unless the domain is dead.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        d1  <= dom;
        d2  <= d1;
        ack <= d2 & ~dead;
    end

    task automatic do_reset();
        rst  = 1'b1;
        req  = 1'b0;
        mask = 4'h0;
        dead = 4'h0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp += 5;
        if (dom !== 4'h0) begin $display("FAIL reset_dom got %h want 0", dom); n_bad++; end
        if (busy !== 1'b1) begin $display("FAIL reset_busy got %b want 1", busy); n_bad++; end
        if (all_ready !== 1'b0) begin $display("FAIL reset_all_ready got %b want 0", all_ready); n_bad++; end
        if (terr !== 1'b0) begin $display("FAIL reset_timeout_err got %b want 0", terr); n_bad++; end
        if (err_dom !== 2'd0) begin $display("FAIL reset_err_dom got %0d want 0", err_dom); n_bad++; end
    endtask

    task automatic test_boot(input string tag, input bit inject);
        int t0;
        int rel;
        int rise[4];
        int exp_rise[4];
        int bfall;
        int arise;
        exp_rise = '{5, 13, 21, 29};
        rise     = '{-1, -1, -1, -1};
        bfall    = -1;
        arise    = -1;
        @(negedge clk);
        rst = 1'b0;
        t0  = cyc;
        repeat (45) begin
            @(negedge clk);
            rel = cyc - t0;
            req = 1'b0;
            if (inject && rel == 2) begin
                req  = 1'b1;
                mask = 4'hF;
            end else if (inject && rel == 15) begin
                req  = 1'b1;
                mask = 4'h1;
            end
            for (int k = 0; k < 4; k++) begin
                if (rise[k] < 0 && dom[k]) rise[k] = rel;
            end
            if (bfall < 0 && !busy) bfall = rel;
            if (arise < 0 && all_ready) arise = rel;
        end
        req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (rise[k] !== exp_rise[k]) begin
                $display("FAIL %s_rise%0d got %0d want %0d", tag, k, rise[k], exp_rise[k]);
                n_bad++;
            end
        end
        n_cmp += 2;
        if (bfall !== 36) begin $display("FAIL %s_busy_fall got %0d want 36", tag, bfall); n_bad++; end
        if (arise !== 36) begin $display("FAIL %s_all_ready_rise got %0d want 36", tag, arise); n_bad++; end
    endtask

    task automatic test_ignore_ready();
        @(negedge clk);
        req  = 1'b1;
        mask = 4'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req = 1'b0;
            n_cmp++;
            if (dom !== 4'hF) begin $display("FAIL ign_dom cycle %0d got %h want f", i, dom); n_bad++; end
        end
        n_cmp += 2;
        if (busy !== 1'b0) begin $display("FAIL ign_busy got %b want 0", busy); n_bad++; end
        if (all_ready !== 1'b1) begin $display("FAIL ign_all_ready got %b want 1", all_ready); n_bad++; end
    endtask

    task automatic test_soft();
        int t0;
        int rel;
        int r1;
        int r3;
        int bfall;
        int arise;
        int bad02;
        r1 = -1; r3 = -1; bfall = -1; arise = -1; bad02 = 0;
        @(negedge clk);
        req  = 1'b1;
        mask = 4'b1010;
        t0   = cyc;
        repeat (30) begin
            @(negedge clk);
            rel  = cyc - t0;
            req  = 1'b0;
            mask = 4'h0;
            if (rel == 1) begin
                n_cmp += 3;
                if (dom !== 4'b0101) begin $display("FAIL soft_dom_low got %h want 5", dom); n_bad++; end
                if (busy !== 1'b1) begin $display("FAIL soft_busy got %b want 1", busy); n_bad++; end
                if (all_ready !== 1'b0) begin $display("FAIL soft_all_ready_low got %b want 0", all_ready); n_bad++; end
            end else begin
                if (r1 < 0 && dom[1]) r1 = rel;
                if (r3 < 0 && dom[3]) r3 = rel;
                if (bfall < 0 && !busy) bfall = rel;
                if (arise < 0 && all_ready) arise = rel;
            end
            if (!dom[0] || !dom[2]) bad02++;
        end
        n_cmp += 5;
        if (r1 !== 6) begin $display("FAIL soft_rise1 got %0d want 6", r1); n_bad++; end
        if (r3 !== 14) begin $display("FAIL soft_rise3 got %0d want 14", r3); n_bad++; end
        if (bfall !== 21) begin $display("FAIL soft_busy_fall got %0d want 21", bfall); n_bad++; end
        if (arise !== 21) begin $display("FAIL soft_all_ready_rise got %0d want 21", arise); n_bad++; end
        if (bad02 !== 0) begin $display("FAIL soft_untouched got %0d low samples want 0", bad02); n_bad++; end
    endtask

`ifdef RST_SEQ_WDOG_EN
    task automatic test_timeout();
        int t0;
        int rel;
        int erise;
        int r3;
        int bfall;
        int ar_seen;
        erise = -1; r3 = -1; bfall = -1; ar_seen = 0;
        do_reset();
        dead = 4'b0100;
        @(negedge clk);
        rst = 1'b0;
        t0  = cyc;
        repeat (60) begin
            @(negedge clk);
            rel = cyc - t0;
            if (erise < 0 && terr) erise = rel;
            if (r3 < 0 && dom[3]) r3 = rel;
            if (bfall < 0 && !busy) bfall = rel;
            if (all_ready) ar_seen++;
        end
        n_cmp += 7;
        if (erise !== 37) begin $display("FAIL to_err_rise got %0d want 37", erise); n_bad++; end
        if (err_dom !== 2'd2) begin $display("FAIL to_err_dom got %0d want 2", err_dom); n_bad++; end
        if (r3 !== 41) begin $display("FAIL to_rise3 got %0d want 41", r3); n_bad++; end
        if (bfall !== 48) begin $display("FAIL to_busy_fall got %0d want 48", bfall); n_bad++; end
        if (ar_seen !== 0) begin $display("FAIL to_all_ready got %0d high samples want 0", ar_seen); n_bad++; end
        if (dom !== 4'hF) begin $display("FAIL to_dom got %h want f", dom); n_bad++; end
        if (terr !== 1'b1) begin $display("FAIL to_err_sticky got %b want 1", terr); n_bad++; end
    endtask
`else
    task automatic test_stuck();
        int busy_low;
        int err_hi;
        busy_low = 0;
        err_hi   = 0;
        do_reset();
        dead = 4'b0100;
        @(negedge clk);
        rst = 1'b0;
        repeat (1100) begin
            @(negedge clk);
            if (!busy) busy_low++;
            if (terr) err_hi++;
        end
        n_cmp += 3;
        if (busy_low !== 0) begin $display("FAIL stuck_busy got %0d low samples want 0", busy_low); n_bad++; end
        if (err_hi !== 0) begin $display("FAIL stuck_err got %0d high samples want 0", err_hi); n_bad++; end
        if (dom !== 4'b0111) begin $display("FAIL stuck_dom got %h want 7", dom); n_bad++; end
    endtask
`endif

    task automatic test_mid_reset();
        int t0;
        int rel;
        dead = 4'h0;
        @(negedge clk);
        req  = 1'b1;
        mask = 4'hF;
        t0   = cyc;
        rel  = 0;
        while (rel < 15) begin
            @(negedge clk);
            rel  = cyc - t0;
            req  = 1'b0;
            mask = 4'h0;
            if (rel == 14) begin
                n_cmp++;
                if (dom !== 4'b0011) begin $display("FAIL mid_dom_wait1 got %h want 3", dom); n_bad++; end
            end
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp += 4;
        if (dom !== 4'h0) begin $display("FAIL mid_dom got %h want 0", dom); n_bad++; end
        if (terr !== 1'b0) begin $display("FAIL mid_err got %b want 0", terr); n_bad++; end
        if (busy !== 1'b1) begin $display("FAIL mid_busy got %b want 1", busy); n_bad++; end
        if (all_ready !== 1'b0) begin $display("FAIL mid_all_ready got %b want 0", all_ready); n_bad++; end
        repeat (4) @(negedge clk);
        test_boot("reboot", 1'b0);
    endtask

    initial begin
        test_reset();
        test_boot("boot", 1'b0);
        test_ignore_ready();
        test_soft();
        do_reset();
        test_boot("boot_ign", 1'b1);
`ifdef RST_SEQ_WDOG_EN
        test_timeout();
`else
        test_stuck();
        do_reset();
        test_boot("recover", 1'b0);
`endif
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
